// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised, oversampled UART receiver.
//
// Takes the asynchronous rxd pad through a 2-flop synchroniser. It samples each
// bit at its middle, with CLKS_PER_BIT clocks per bit. The received word is
// presented through a one-entry holding register with a valid/ready handshake.
// Parity, framing and overrun errors are reported.
//
// Parameters:
//   DATA_BITS    data bits per frame (5..9), LSB first on the line
//   CLKS_PER_BIT clocks per bit period (even, >= 4)
//   PARITY       0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rxd         in   serial line, idle high, asynchronous to clk
//   rx_data     out  received word (held)
//   rx_valid    out  rx_data holds an unconsumed word
//   rx_ready    in   consumer accepts the word when rx_valid & rx_ready
//   parity_err  out  parity mismatch on the held word
//   frame_err   out  a stop bit sampled low on the held word
//   overrun     out  one-cycle pulse when a completed frame is dropped
//   brk         out  one-cycle break pulse (0 unless UART_RX_BREAK_EN)
//
// Optional feature macro: UART_RX_BREAK_EN
//   Defined: a frame whose data, parity and stop samples are all 0 is a break.
//   It pulses brk, is not delivered, and the FSM waits in BRKWAIT until the
//   line returns high.
//   Undefined: such a frame is delivered as data 0 with frame_err set.
//
// Handshake: a word transfers on every rising edge where rx_valid & rx_ready.
// rx_valid then drops unless a new frame completes on that same edge. In that
// case the new word replaces the consumed one and rx_valid stays high. A frame
// that completes while rx_valid=1 and rx_ready=0 is dropped and overrun pulses.
// parity_err/frame_err belong to the held word and change only when a word loads.
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 brk
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_BIT       = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PAR     = 3'd3,
    S_STOP    = 3'd4
`ifdef UART_RX_BREAK_EN
    , S_BRKWAIT = 3'd5
`endif
  } state_e;

  // Synchroniser: sync_q[1] is the only copy of the line the logic looks at.
  logic [1:0]           sync_q, sync_d;
  logic                 rxd_s;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 acc_perr_q, acc_perr_d;   // parity result of the frame in flight
  logic                 acc_ferr_q, acc_ferr_d;   // any stop sample low so far

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic                 complete;   // last stop sample taken this cycle
  logic                 deliver;    // completed frame goes to the holding register

`ifdef UART_RX_BREAK_EN
  logic                 zero_q, zero_d;   // every sample of the frame so far was 0
  logic                 is_break;
  logic                 brk_q, brk_d;
`endif

  assign sync_d = {sync_q[0], rxd};
  assign rxd_s  = sync_q[1];

  // ---------------------------------------------------------------------------
  // State register (all flops)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      acc_perr_q   <= 1'b0;
      acc_ferr_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_EN
      zero_q       <= 1'b0;
      brk_q        <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      acc_perr_q   <= acc_perr_d;
      acc_ferr_q   <= acc_ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_EN
      zero_q       <= zero_d;
      brk_q        <= brk_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: frame sequencing and the receive datapath
  // ---------------------------------------------------------------------------
  always_comb begin : next_state_comb
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    acc_perr_d = acc_perr_q;
    acc_ferr_d = acc_ferr_q;
    complete   = 1'b0;
`ifdef UART_RX_BREAK_EN
    zero_d     = zero_q;
    is_break   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      // Re-check the start bit half a bit later; a high line means a glitch.
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_DATA;
            idx_d      = '0;
            acc_perr_d = 1'b0;
            acc_ferr_d = 1'b0;
`ifdef UART_RX_BREAK_EN
            zero_d     = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // From here on cnt wraps every full bit, so each sample lands mid-bit.
      S_DATA: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_EN
          zero_d  = zero_q & ~rxd_s;
`endif
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PAR: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d      = '0;
          acc_perr_d = (^shift_q) ^ rxd_s ^ PAR_ODD;
`ifdef UART_RX_BREAK_EN
          zero_d     = zero_q & ~rxd_s;
`endif
          state_d    = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // idx is reused to count stop bits. The FSM leaves at mid-stop-bit, so
      // the next start edge can follow the stop bit without any idle gap.
      S_STOP: begin
        if (cnt_q == CNT_BIT) begin
          cnt_d      = '0;
          acc_ferr_d = acc_ferr_q | ~rxd_s;
`ifdef UART_RX_BREAK_EN
          zero_d     = zero_q & ~rxd_s;
`endif
          if (idx_q == IDX_STOP_LAST) begin
            idx_d    = '0;
            complete = 1'b1;
            state_d  = S_IDLE;
`ifdef UART_RX_BREAK_EN
            is_break = zero_q & ~rxd_s;
            if (is_break) state_d = S_BRKWAIT;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_BREAK_EN
      // A held-low break line must not look like a stream of start bits.
      S_BRKWAIT: begin
        if (rxd_s) state_d = S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: holding register, handshake and event pulses
  // ---------------------------------------------------------------------------
  always_comb begin : output_comb
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
`ifdef UART_RX_BREAK_EN
    brk_d        = complete & is_break;
    deliver      = complete & ~is_break;
`else
    deliver      = complete;
`endif

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (deliver) begin
      // A consume on the same edge frees the register for the new word.
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        parity_err_d = acc_perr_q;
        frame_err_d  = acc_ferr_d;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_BREAK_EN
  assign brk        = brk_q;
`else
  assign brk        = 1'b0;
`endif

endmodule
